// File: rtl/riscv_str_seq.sv
// In-place string sequencer: it loads each word, transforms the bytes before the first NUL and
// stores them back with byte enables, using a req/gnt/rvalid data-memory port.
package riscv_defines;
  localparam int STR_OP_WIDTH = 2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;
endpackage

module riscv_str_seq
  import riscv_defines::*;
#(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [31:0]             len_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic [31:0]             data_addr_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [31:0]             data_wdata_o,
  input  logic [31:0]             data_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, STORE_REQ, STORE_WAIT, DONE
  } state_e;

  state_e                  state_q;
  logic [STR_OP_WIDTH-1:0] op_q;
  logic [31:0]             addr_q, cnt_q, len_q, wdata_q;
  logic [3:0]              be_q;
  logic [2:0]              k_q, k_d;
  logic                    req_q, we_q, err_q;
  logic [31:0]             wdata_d;
  logic [3:0]              be_d;

  function automatic logic [7:0] xform(input logic [STR_OP_WIDTH-1:0] op, input logic [7:0] b);
    logic [7:0] r;
    r = b;
    case (op)
      STR_OP_UPPER: if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
      STR_OP_LOWER: if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
      STR_OP_LEET: begin
        // Setting bit 5 folds upper-case letters onto lower case and cannot make a non-letter match.
        case (b | 8'h20)
          8'h61:   r = 8'h34;
          8'h65:   r = 8'h33;
          8'h69:   r = 8'h31;
          8'h6F:   r = 8'h30;
          8'h73:   r = 8'h35;
          8'h74:   r = 8'h37;
          default: r = b;
        endcase
      end
      default: begin
        if ((b >= 8'h61 && b <= 8'h6D) || (b >= 8'h41 && b <= 8'h4D)) r = b + 8'd13;
        else if ((b >= 8'h6E && b <= 8'h7A) || (b >= 8'h4E && b <= 8'h5A)) r = b - 8'd13;
      end
    endcase
    return r;
  endfunction

  // Find the lowest NUL byte (k = 4 if there is none). Bytes before it are transformed; the NUL and later bytes keep their loaded value.
  always_comb begin
    k_d     = 3'd4;
    be_d    = '0;
    wdata_d = data_rdata_i;
    for (int unsigned j = 4; j > 0; j--) begin
      if (data_rdata_i[(j-1)*8 +: 8] == 8'h00) k_d = 3'(j - 1);
    end
    for (int unsigned j = 0; j < 4; j++) begin
      if (3'(j) < k_d) begin
        be_d[j]           = 1'b1;
        wdata_d[j*8 +: 8] = xform(op_q, data_rdata_i[j*8 +: 8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      k_q     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q   <= operator_i;
            addr_q <= {addr_i[31:2], 2'b00};
            len_q  <= '0;
            cnt_q  <= '0;
            if (addr_i[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              be_q    <= '1;
              state_q <= LOAD_REQ;
            end
          end
        end
        LOAD_REQ: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (data_rvalid_i) begin
            k_q   <= k_d;
            len_q <= len_q + {29'd0, k_d};
            if (k_d == 3'd0) begin
              state_q <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              be_q    <= be_d;
              wdata_q <= wdata_d;
              state_q <= STORE_REQ;
            end
          end
        end
        STORE_REQ: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= STORE_WAIT;
          end
        end
        STORE_WAIT: begin
          if (data_rvalid_i) begin
            if (k_q < 3'd4) begin
              state_q <= DONE;
            end else begin
              addr_q <= addr_q + 32'd4;
              cnt_q  <= cnt_q + 32'd1;
              if (cnt_q + 32'd1 == 32'(MAX_WORDS)) begin
                err_q   <= 1'b1;
                state_q <= DONE;
              end else begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                be_q    <= '1;
                state_q <= LOAD_REQ;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;
  assign len_o        = len_q;
  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_str_seq.sv
// Directed bench for riscv_str_seq: a behavioural word memory with programmable grant latency
// answers the DUT's requests, and each scenario task checks its results against hand-computed values.
module tb_riscv_str_seq;
  import riscv_defines::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_i = 1'b0;
  logic [STR_OP_WIDTH-1:0] operator_i = '0;
  logic [31:0]             addr_i = '0;
  logic                    busy_o, done_o, err_o;
  logic [31:0]             len_o;
  logic                    data_req_o, data_we_o;
  logic                    data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0]             data_addr_o, data_wdata_o;
  logic [31:0]             data_rdata_i = '0;
  logic [3:0]              data_be_o;

  riscv_str_seq #(.MAX_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .operator_i(operator_i), .addr_i(addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .len_o(len_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];
  int          gnt_delay = 0;
  int          loads = 0, stores = 0;
  logic        unstable = 1'b0;
  logic [31:0] st_addr [0:7];
  logic [31:0] st_wd   [0:7];
  logic [3:0]  st_be   [0:7];

  // Memory responder: grant after gnt_delay request cycles, answer with rvalid on the following cycle.
  initial begin
    int          wcnt;
    logic        pend;
    logic [31:0] pend_data, snap_addr, snap_wd;
    logic [3:0]  snap_be;
    wcnt = 0; pend = 1'b0; pend_data = '0;
    snap_addr = '0; snap_wd = '0; snap_be = '0;
    forever begin
      @(negedge clk);
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        wcnt = 0;
      end else if (pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = pend_data;
        pend = 1'b0;
      end else if (data_req_o) begin
        if (wcnt == 0) begin
          snap_addr = data_addr_o; snap_be = data_be_o; snap_wd = data_wdata_o;
        end else if (snap_addr !== data_addr_o || snap_be !== data_be_o || snap_wd !== data_wdata_o) begin
          unstable = 1'b1;
        end
        if (wcnt >= gnt_delay) begin
          data_gnt_i = 1'b1;
          wcnt = 0;
          pend = 1'b1;
          if (data_we_o) begin
            for (int b = 0; b < 4; b++)
              if (data_be_o[b]) mem[data_addr_o[9:2]][b*8 +: 8] = data_wdata_o[b*8 +: 8];
            if (stores < 8) begin
              st_addr[stores] = data_addr_o; st_be[stores] = data_be_o; st_wd[stores] = data_wdata_o;
            end
            stores++;
            pend_data = '0;
          end else begin
            pend_data = mem[data_addr_o[9:2]];
            loads++;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic clear_log();
    loads = 0; stores = 0; unstable = 1'b0;
  endtask

  // Issues one start command and waits (bounded) for done_o; cyc counts cycles after the start cycle.
  task automatic run(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] a, output int cyc,
                     output logic busy1, output logic req1, output logic err_d, output logic [31:0] len_d);
    @(negedge clk);
    start_i = 1'b1; operator_i = op; addr_i = a;
    @(negedge clk);
    start_i = 1'b0;
    busy1 = busy_o; req1 = data_req_o; cyc = 1;
    while (!done_o && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    err_d = err_o; len_d = len_o;
  endtask

  task automatic test_reset();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
    tests++; if (data_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", data_req_o); end
    tests++; if (len_o !== 32'd0) begin fails++; $display("FAIL reset_len: got %h want 0", len_o); end
    tests++; if ({data_addr_o, data_be_o, data_wdata_o} !== 68'd0) begin fails++;
      $display("FAIL reset_bus: got addr %h be %b wdata %h want zeros", data_addr_o, data_be_o, data_wdata_o); end
  endtask

  task automatic test_upper();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 0; clear_log();
    mem[8'h40] = 32'h00636261;
    run(STR_OP_UPPER, 32'h100, cyc, b1, r1, e, l);
    tests++; if (cyc !== 5) begin fails++; $display("FAIL upper_latency: got %0d want 5", cyc); end
    tests++; if ({b1, r1} !== 2'b11) begin fails++; $display("FAIL upper_cycle1: got busy,req %b want 11", {b1, r1}); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL upper_err: got %b want 0", e); end
    tests++; if (l !== 32'd3) begin fails++; $display("FAIL upper_len: got %0d want 3", l); end
    tests++; if (stores !== 1 || loads !== 1) begin fails++; $display("FAIL upper_txns: got %0d ld %0d st want 1 1", loads, stores); end
    tests++; if (st_addr[0] !== 32'h100) begin fails++; $display("FAIL upper_addr: got %h want 00000100", st_addr[0]); end
    tests++; if (st_be[0] !== 4'b0111) begin fails++; $display("FAIL upper_be: got %b want 0111", st_be[0]); end
    tests++; if (st_wd[0] !== 32'h00434241) begin fails++; $display("FAIL upper_wdata: got %h want 00434241", st_wd[0]); end
    @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL upper_busy_fall: got %b want 0", busy_o); end
    tests++; if (len_o !== 32'd3) begin fails++; $display("FAIL upper_len_hold: got %0d want 3", len_o); end
  endtask

  task automatic test_leet();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 0; clear_log();
    mem[8'h50] = 32'h74736574; mem[8'h51] = 32'h0;
    run(STR_OP_LEET, 32'h140, cyc, b1, r1, e, l);
    tests++; if (st_wd[0] !== 32'h37353337) begin fails++; $display("FAIL leet_wdata: got %h want 37353337", st_wd[0]); end
    tests++; if (st_be[0] !== 4'b1111) begin fails++; $display("FAIL leet_be: got %b want 1111", st_be[0]); end
    tests++; if (loads !== 2 || stores !== 1) begin fails++; $display("FAIL leet_txns: got %0d ld %0d st want 2 1", loads, stores); end
    tests++; if (l !== 32'd4 || e !== 1'b0) begin fails++; $display("FAIL leet_len_err: got %0d/%b want 4/0", l, e); end
    tests++; if (cyc !== 7) begin fails++; $display("FAIL leet_latency: got %0d want 7", cyc); end
  endtask

  task automatic test_rot13_lower();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 0; clear_log();
    mem[8'h60] = 32'h00217A5A;
    run(STR_OP_ROT13, 32'h180, cyc, b1, r1, e, l);
    tests++; if (st_wd[0] !== 32'h00216D4D || st_be[0] !== 4'b0111) begin fails++;
      $display("FAIL rot13_store: got %h/%b want 00216d4d/0111", st_wd[0], st_be[0]); end
    tests++; if (l !== 32'd3) begin fails++; $display("FAIL rot13_len: got %0d want 3", l); end
    clear_log();
    mem[8'h70] = 32'h4C4C4548; mem[8'h71] = 32'h0;
    run(STR_OP_LOWER, 32'h1C0, cyc, b1, r1, e, l);
    tests++; if (st_wd[0] !== 32'h6C6C6568) begin fails++; $display("FAIL lower_wdata: got %h want 6c6c6568", st_wd[0]); end
    tests++; if (mem[8'h70] !== 32'h6C6C6568) begin fails++; $display("FAIL lower_mem: got %h want 6c6c6568", mem[8'h70]); end
    clear_log();
    mem[8'h74] = 32'h61006262;
    run(STR_OP_UPPER, 32'h1D0, cyc, b1, r1, e, l);
    tests++; if (st_wd[0] !== 32'h61004242 || st_be[0] !== 4'b0011) begin fails++;
      $display("FAIL passthru_store: got %h/%b want 61004242/0011", st_wd[0], st_be[0]); end
    tests++; if (l !== 32'd2) begin fails++; $display("FAIL passthru_len: got %0d want 2", l); end
  endtask

  task automatic test_misaligned();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 0; clear_log();
    run(STR_OP_UPPER, 32'h102, cyc, b1, r1, e, l);
    tests++; if (cyc !== 1) begin fails++; $display("FAIL misal_latency: got %0d want 1", cyc); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL misal_err: got %b want 1", e); end
    tests++; if (r1 !== 1'b0 || loads + stores !== 0) begin fails++;
      $display("FAIL misal_noreq: got req %b txns %0d want 0 0", r1, loads + stores); end
    tests++; if (l !== 32'd0) begin fails++; $display("FAIL misal_len: got %0d want 0", l); end
  endtask

  task automatic test_empty();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 0; clear_log();
    mem[8'h78] = 32'h41414100;
    run(STR_OP_UPPER, 32'h1E0, cyc, b1, r1, e, l);
    tests++; if (loads !== 1 || stores !== 0) begin fails++; $display("FAIL empty_txns: got %0d ld %0d st want 1 0", loads, stores); end
    tests++; if (l !== 32'd0 || e !== 1'b0) begin fails++; $display("FAIL empty_len_err: got %0d/%b want 0/0", l, e); end
    tests++; if (cyc !== 3) begin fails++; $display("FAIL empty_latency: got %0d want 3", cyc); end
  endtask

  task automatic test_max_words();
    int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 3; clear_log();
    mem[8'h80] = 32'h64636261; mem[8'h81] = 32'h68676665; mem[8'h82] = 32'h6A6A6A6A;
    run(STR_OP_UPPER, 32'h200, cyc, b1, r1, e, l);
    tests++; if (loads !== 2 || stores !== 2) begin fails++; $display("FAIL max_txns: got %0d ld %0d st want 2 2", loads, stores); end
    tests++; if (e !== 1'b1 || l !== 32'd8) begin fails++; $display("FAIL max_err_len: got %b/%0d want 1/8", e, l); end
    tests++; if (mem[8'h80] !== 32'h44434241 || mem[8'h81] !== 32'h48474645) begin fails++;
      $display("FAIL max_mem: got %h %h want 44434241 48474645", mem[8'h80], mem[8'h81]); end
    tests++; if (st_addr[1] !== 32'h204) begin fails++; $display("FAIL max_addr2: got %h want 00000204", st_addr[1]); end
    tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL req_stable: got %b want 0", unstable); end
    tests++; if (cyc !== 21) begin fails++; $display("FAIL max_latency: got %0d want 21", cyc); end
    gnt_delay = 0;
  endtask

  task automatic test_reset_mid();
    int n; int cyc; logic b1, r1, e; logic [31:0] l;
    gnt_delay = 3; clear_log();
    mem[8'h40] = 32'h00636261;
    @(negedge clk);
    start_i = 1'b1; operator_i = STR_OP_UPPER; addr_i = 32'h100;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(data_req_o && data_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++; if (n >= 100) begin fails++; $display("FAIL midrst_reach_store: got %0d cycles want <100", n); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({data_req_o, busy_o} !== 2'b00 || len_o !== 32'd0) begin fails++;
      $display("FAIL midrst_clear: got req %b busy %b len %0d want 0 0 0", data_req_o, busy_o, len_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0; clear_log();
    mem[8'h40] = 32'h00636261;
    run(STR_OP_UPPER, 32'h100, cyc, b1, r1, e, l);
    tests++; if (cyc !== 5 || l !== 32'd3 || e !== 1'b0) begin fails++;
      $display("FAIL midrst_rerun: got cyc %0d len %0d err %b want 5 3 0", cyc, l, e); end
    tests++; if (st_wd[0] !== 32'h00434241) begin fails++; $display("FAIL midrst_wdata: got %h want 00434241", st_wd[0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_upper();
    test_leet();
    test_rot13_lower();
    test_misaligned();
    test_empty();
    test_max_words();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
